interface_sensor_multicanal: RTL



---
 rtl/sensor_pkg.sv | 27 ++
 rtl/contador_cm_bcd.sv | 40 ++++
 rtl/interface_sensor_multicanal.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared state codes and BCD measurement constants for the multichannel
// ultrasonic sensor interface.
package sensor_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    ENVIA_TRIGGER = 4'd2,
    ESPERA_ECHO   = 4'd3,
    MEDIDA        = 4'd4,
    ARMAZENA      = 4'd5,
    PROXIMO       = 4'd6,
    FINAL         = 4'd7
  } estado_t;

  localparam int BCD_DIGITO_W = 4;
  localparam int BCD_DIGITOS  = 3;
  localparam int MEDIDA_W     = BCD_DIGITO_W * BCD_DIGITOS;
  localparam int CANAL_W      = 3;

  localparam logic [MEDIDA_W-1:0] MEDIDA_SAT = 12'h999;

  function automatic logic [BCD_DIGITO_W-1:0] bcd_inc(input logic [BCD_DIGITO_W-1:0] d);
    return (d == 4'd9) ? '0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/contador_cm_bcd.sv
// Three-digit BCD centimetre counter with synchronous clear, count enable and
// saturation at 999; shared by all channels of the sensor interface.
module contador_cm_bcd
  import sensor_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                limpa,
  input  logic                conta,
  output logic [MEDIDA_W-1:0] valor
);

  logic [BCD_DIGITOS-1:0] noves;
  logic                   habilita;

  assign habilita = conta && (valor != MEDIDA_SAT);

  for (genvar gi = 0; gi < BCD_DIGITOS; gi++) begin : g_digito
    // A digit advances when every lower digit is at 9 (ripple carry).
    localparam logic [BCD_DIGITOS-1:0] MASCARA = BCD_DIGITOS'((1 << gi) - 1);

    logic [BCD_DIGITO_W-1:0] digito_reg;
    logic                    carry_in;

    assign carry_in  = habilita && ((noves & MASCARA) == MASCARA);
    assign noves[gi] = (digito_reg == 4'd9);
    assign valor[gi*BCD_DIGITO_W +: BCD_DIGITO_W] = digito_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        digito_reg <= '0;
      end else if (limpa) begin
        digito_reg <= '0;
      end else if (carry_in) begin
        digito_reg <= bcd_inc(digito_reg);
      end
    end
  end

endmodule

// File: rtl/interface_sensor_multicanal.sv
// Multichannel HC-SR04 interface: triggers and measures each channel in turn
// on one request, storing rounded BCD centimetres and a timeout flag per channel.
module interface_sensor_multicanal
  import sensor_pkg::*;
#(
  parameter int N_CANAIS       = 2,
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_POR_CM  = 2941,
  parameter int TIMEOUT_CICLOS = 1_500_000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         medir,
  input  logic [N_CANAIS-1:0]          echo,
  output logic [N_CANAIS-1:0]          trigger,
  output logic [MEDIDA_W*N_CANAIS-1:0] medidas,
  output logic [N_CANAIS-1:0]          erro,
  output logic                         pronto,
  output logic [3:0]                   db_estado,
  output logic [2:0]                   db_canal
);

  localparam int MAX_CANAIS = 1 << CANAL_W;
  localparam int TICK_W     = $clog2(CICLOS_POR_CM + 1);
  localparam int TEMPO_W    = $clog2(TIMEOUT_CICLOS + 1);
  localparam int TRIG_W     = $clog2(TRIGGER_CICLOS + 1);

  localparam logic [TICK_W-1:0]  TICK_FIM     = TICK_W'(CICLOS_POR_CM - 1);
  localparam logic [TICK_W-1:0]  TICK_INICIO  = TICK_W'(CICLOS_POR_CM / 2);
  localparam logic [TEMPO_W-1:0] TEMPO_FIM    = TEMPO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [TRIG_W-1:0]  TRIG_FIM     = TRIG_W'(TRIGGER_CICLOS - 1);
  localparam logic [CANAL_W-1:0] CANAL_ULTIMO = CANAL_W'(N_CANAIS - 1);

  estado_t               estado_reg;
  logic [CANAL_W-1:0]    canal_reg;
  logic [TICK_W-1:0]     tick_reg;
  logic [TEMPO_W-1:0]    tempo_reg;
  logic [TRIG_W-1:0]     trig_cnt_reg;
  logic [N_CANAIS-1:0]   trigger_reg;
  logic                  pronto_reg;
  logic                  timeout_reg;

  logic [MAX_CANAIS-1:0] sync_pad;
  logic [MAX_CANAIS-1:0] prev_pad;
  logic                  echo_sobe;
  logic                  echo_desce;
  logic                  cm_limpa;
  logic                  cm_conta;
  logic                  grava;
  logic [MEDIDA_W-1:0]   cm_valor;

  // Synchronizers are padded to eight lanes so the channel mux index is full width.
  for (genvar gi = 0; gi < MAX_CANAIS; gi++) begin : g_sync
    if (gi < N_CANAIS) begin : g_ativo
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= echo[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign sync_pad[gi] = sync_reg;
      assign prev_pad[gi] = prev_reg;
    end else begin : g_vazio
      assign sync_pad[gi] = 1'b0;
      assign prev_pad[gi] = 1'b0;
    end
  end

  assign echo_sobe  =  sync_pad[canal_reg] && !prev_pad[canal_reg];
  assign echo_desce = !sync_pad[canal_reg] &&  prev_pad[canal_reg];

  assign cm_limpa = (estado_reg == PREPARACAO);
  assign cm_conta = (estado_reg == MEDIDA) && (tick_reg == TICK_FIM);
  assign grava    = (estado_reg == ARMAZENA);

  contador_cm_bcd u_contador_cm (
    .clock (clock),
    .reset (reset),
    .limpa (cm_limpa),
    .conta (cm_conta),
    .valor (cm_valor)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg   <= INICIAL;
      canal_reg    <= '0;
      tick_reg     <= '0;
      tempo_reg    <= '0;
      trig_cnt_reg <= '0;
      trigger_reg  <= '0;
      pronto_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (estado_reg)
        INICIAL: begin
          if (medir) begin
            canal_reg  <= '0;
            estado_reg <= PREPARACAO;
          end
        end
        PREPARACAO: begin
          // Preloading half a centimetre turns the truncating count into round-to-nearest.
          tick_reg     <= TICK_INICIO;
          tempo_reg    <= '0;
          trig_cnt_reg <= '0;
          timeout_reg  <= 1'b0;
          for (int i = 0; i < N_CANAIS; i++) begin
            trigger_reg[i] <= (canal_reg == CANAL_W'(i));
          end
          estado_reg <= ENVIA_TRIGGER;
        end
        ENVIA_TRIGGER: begin
          if (trig_cnt_reg == TRIG_FIM) begin
            trigger_reg <= '0;
            estado_reg  <= ESPERA_ECHO;
          end else begin
            trig_cnt_reg <= trig_cnt_reg + TRIG_W'(1);
          end
        end
        ESPERA_ECHO: begin
          if (echo_sobe) begin
            tempo_reg  <= '0;
            estado_reg <= MEDIDA;
          end else if (tempo_reg == TEMPO_FIM) begin
            timeout_reg <= 1'b1;
            estado_reg  <= ARMAZENA;
          end else begin
            tempo_reg <= tempo_reg + TEMPO_W'(1);
          end
        end
        MEDIDA: begin
          tick_reg <= (tick_reg == TICK_FIM) ? '0 : tick_reg + TICK_W'(1);
          if (echo_desce) begin
            estado_reg <= ARMAZENA;
          end else if (tempo_reg == TEMPO_FIM) begin
            timeout_reg <= 1'b1;
            estado_reg  <= ARMAZENA;
          end else begin
            tempo_reg <= tempo_reg + TEMPO_W'(1);
          end
        end
        ARMAZENA: begin
          estado_reg <= PROXIMO;
        end
        PROXIMO: begin
          if (canal_reg == CANAL_ULTIMO) begin
            pronto_reg <= 1'b1;
            estado_reg <= FINAL;
          end else begin
            canal_reg  <= canal_reg + CANAL_W'(1);
            estado_reg <= PREPARACAO;
          end
        end
        FINAL: begin
          pronto_reg <= 1'b0;
          estado_reg <= INICIAL;
        end
        default: begin
          estado_reg <= INICIAL;
        end
      endcase
    end
  end

  // Result register file: only the channel just measured is written.
  for (genvar gi = 0; gi < N_CANAIS; gi++) begin : g_canal
    logic [MEDIDA_W-1:0] medida_reg;
    logic                erro_reg;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        medida_reg <= '0;
        erro_reg   <= 1'b0;
      end else if (grava && (canal_reg == CANAL_W'(gi))) begin
        if (timeout_reg) begin
          medida_reg <= MEDIDA_SAT;
          erro_reg   <= 1'b1;
        end else begin
          medida_reg <= cm_valor;
          erro_reg   <= 1'b0;
        end
      end
    end

    assign medidas[gi*MEDIDA_W +: MEDIDA_W] = medida_reg;
    assign erro[gi]                         = erro_reg;
  end

  assign trigger   = trigger_reg;
  assign pronto    = pronto_reg;
  assign db_estado = estado_reg;
  assign db_canal  = canal_reg;

endmodule
